// File: rtl/conv_acc_pkg.sv
// conv_acc_pkg
// Shared definitions for the convolution accelerator output path:
//   LANE_W    - width of one quantized output lane (int8)
//   DEF_S     - default number of lanes per output-feature-map row
//   beats_of  - number of output beats needed to carry one quantized row
//   sat8      - signed saturation of a 33-bit value into int8
//   ofm_row_t - packed quantized row for the default lane count
package conv_acc_pkg;

   localparam int LANE_W = 8;
   localparam int DEF_S  = 64;

   typedef logic [LANE_W*DEF_S-1:0] ofm_row_t;

   function automatic int beats_of(input int s, input int out_w);
      return (LANE_W * s) / out_w;
   endfunction

   // Clamp to the int8 range; in-range values keep their low byte,
   // which is already the correct two's-complement encoding.
   function automatic logic [LANE_W-1:0] sat8(input logic signed [32:0] v);
      logic [LANE_W-1:0] r;
      if (v > 33'sd127) begin
         r = 8'h7F;
      end else if (v < -33'sd128) begin
         r = 8'h80;
      end else begin
         r = v[LANE_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/row_fifo.sv
// row_fifo
// Synchronous single-clock FIFO holding whole quantized rows.
// The head entry is presented on pop_data without waiting for a read
// request (fall-through), so the consumer can slice it directly.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   push          - write push_data this cycle (ignored when full)
//   push_data     - row to store
//   pop           - discard the head entry this cycle (ignored when empty)
//   pop_data      - current head entry (undefined contents when empty)
//   full, empty   - occupancy flags
//   count         - number of stored entries, 0..DEPTH
module row_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: an entry is only visible once written.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/ofm_requant_pack.sv
// ofm_requant_pack
// Requantizes S-lane 32-bit partial-sum rows from the convolution core to
// int8 (optional ReLU, rounding arithmetic right shift, saturation),
// buffers them and emits them as OUT_W-bit valid/ready beats.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   cfg_shift          - rounding right-shift amount (static during a layer)
//   cfg_relu           - clamp negative inputs to zero before shifting
//   ofm_port, _v       - input row and its valid (taken every valid cycle)
//   end_op             - layer-finished pulse from the core
//   stall              - registered backpressure toward the core
//   m_data/valid/ready - output beats, lane 0 in the low byte of beat 0
//   m_last             - marks the final beat of each row
//   frame_done         - one-cycle pulse once a finished layer has drained
//   ovf_err            - sticky flag: a row was dropped because the FIFO was full
// IN_W must not exceed 32 (the quantizer works in 33-bit signed arithmetic).
module ofm_requant_pack
   import conv_acc_pkg::*;
#(
   parameter int S            = DEF_S,
   parameter int IN_W         = 32,
   parameter int OUT_W        = 128,
   parameter int FIFO_DEPTH   = 8,
   parameter int STALL_MARGIN = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4:0]          cfg_shift,
   input  logic                cfg_relu,
   input  logic [IN_W*S-1:0]   ofm_port,
   input  logic                ofm_port_v,
   input  logic                end_op,
   output logic                stall,
   output logic [OUT_W-1:0]    m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic                m_last,
   output logic                frame_done,
   output logic                ovf_err
);

   localparam int BEATS    = beats_of(S, OUT_W);
   localparam int ROW_W    = LANE_W * S;
   localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int STALL_TH = FIFO_DEPTH - STALL_MARGIN;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   logic                s1_v_q, s1_v_d;
   logic [IN_W*S-1:0]   s1_data_q, s1_data_d;
   logic [ROW_W-1:0]    q_row;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [ROW_W-1:0]    fifo_head;
   logic [CNT_W-1:0]    fifo_count;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                stall_q, stall_d;
   logic                ovf_q, ovf_d;
   logic                pend_q, pend_d;
   logic                beat_fire;
   logic                idle;

   // Input stage: the row is held until the next valid row replaces it.
   always_comb begin
      s1_v_d    = ofm_port_v;
      s1_data_d = ofm_port_v ? ofm_port : s1_data_q;
   end

   // Per-lane requantization from S1. The rounding constant is added in
   // 33 bits so that 0x7FFFFFFF + 2^(shift-1) cannot wrap.
   always_comb begin
      logic [IN_W-1:0]    lane;
      logic signed [32:0] x;
      logic signed [32:0] rnd;
      q_row = '0;
      lane  = '0;
      x     = '0;
      rnd   = '0;
      for (int i = 0; i < S; i++) begin
         lane = s1_data_q[IN_W*i +: IN_W];
         x    = {{(33-IN_W){lane[IN_W-1]}}, lane};
         if (cfg_relu && x[32]) begin
            x = '0;
         end
         if (cfg_shift != 5'd0) begin
            rnd = 33'sd1 <<< (cfg_shift - 5'd1);
            x   = (x + rnd) >>> cfg_shift;
         end
         q_row[LANE_W*i +: LANE_W] = sat8(x);
      end
   end

   // A row arriving into a full FIFO is dropped and flagged.
   always_comb begin
      fifo_push = s1_v_q & ~fifo_full;
      ovf_d     = ovf_q | (s1_v_q & fifo_full);
   end

   row_fifo #(
      .WIDTH (ROW_W),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (q_row),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Beat sequencing over the FIFO head; the head is popped on the
   // handshake of its last beat.
   always_comb begin
      m_valid   = ~fifo_empty;
      beat_fire = m_valid & m_ready;
      m_last    = m_valid & (beat_q == LAST_BEAT);
      fifo_pop  = beat_fire & (beat_q == LAST_BEAT);
      m_data    = '0;
      if (m_valid) begin
         m_data = fifo_head[int'(beat_q)*OUT_W +: OUT_W];
      end
      beat_d = beat_q;
      if (beat_fire) begin
         beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      end
   end

   // Occupancy includes the row sitting in S1, since it is already committed
   // to a FIFO slot one cycle later.
   always_comb begin
      stall_d = (int'(fifo_count) + int'(s1_v_q)) >= STALL_TH;
   end

   // Frame tracking: end_op is remembered until the pipeline is empty.
   // While a pending frame exists, further end_op pulses are absorbed.
   always_comb begin
      idle       = ~s1_v_q & fifo_empty & (beat_q == '0);
      frame_done = pend_q & idle;
      pend_d     = pend_q ? ~idle : end_op;
   end

   assign stall   = stall_q;
   assign ovf_err = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_data_q <= '0;
         beat_q    <= '0;
         stall_q   <= 1'b0;
         ovf_q     <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_data_q <= s1_data_d;
         beat_q    <= beat_d;
         stall_q   <= stall_d;
         ovf_q     <= ovf_d;
         pend_q    <= pend_d;
      end
   end

endmodule

// File: tb/tb_ofm_requant_pack.sv
// tb_ofm_requant_pack
// Drives randomized rows through ofm_requant_pack and compares every output
// beat against a plain-arithmetic requantization model and an ordered queue.
module tb_ofm_requant_pack;

   localparam int S     = 64;
   localparam int IN_W  = 32;
   localparam int OUT_W = 128;

   logic              clk = 1'b0;
   logic              rst;
   logic [4:0]        cfg_shift;
   logic              cfg_relu;
   logic [IN_W*S-1:0] ofm_port;
   logic              ofm_port_v;
   logic              end_op;
   logic              stall;
   logic [OUT_W-1:0]  m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;
   logic              frame_done;
   logic              ovf_err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [8*S-1:0] exp_q [$];

   always #5 clk = ~clk;

   ofm_requant_pack #(
      .S            (S),
      .IN_W         (IN_W),
      .OUT_W        (OUT_W),
      .FIFO_DEPTH   (8),
      .STALL_MARGIN (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_shift  (cfg_shift),
      .cfg_relu   (cfg_relu),
      .ofm_port   (ofm_port),
      .ofm_port_v (ofm_port_v),
      .end_op     (end_op),
      .stall      (stall),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last),
      .frame_done (frame_done),
      .ovf_err    (ovf_err)
   );

   // Reference quantizer: floor((a + 2^(s-1)) / 2^s) with explicit floor
   // correction for negative numerators, then clamp to int8.
   function automatic logic [7:0] q_model(input logic [31:0] x, input int sh, input bit relu);
      longint a, d, num, q;
      a = longint'(signed'(x));
      if (relu && a < 0) a = 0;
      if (sh == 0) begin
         q = a;
      end else begin
         d   = longint'(1) << sh;
         num = a + d / 2;
         q   = num / d;
         if ((num % d) != 0 && num < 0) q = q - 1;
      end
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return 8'(q);
   endfunction

   function automatic logic [8*S-1:0] row_model(input logic [IN_W*S-1:0] r, input int sh, input bit relu);
      logic [8*S-1:0] o;
      o = '0;
      for (int i = 0; i < S; i++) o[8*i +: 8] = q_model(r[32*i +: 32], sh, relu);
      return o;
   endfunction

   task automatic rand_row(output logic [IN_W*S-1:0] r);
      r = '0;
      for (int i = 0; i < S; i++) begin
         case ($urandom_range(0, 2))
            0:       r[32*i +: 32] = $urandom;
            1:       r[32*i +: 32] = 32'($urandom_range(0, 1000)) - 32'd500;
            default: r[32*i +: 32] = 32'($urandom_range(0, 200000)) - 32'd100000;
         endcase
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; cfg_shift = 5'd0; cfg_relu = 1'b0; ofm_port = '0;
      ofm_port_v = 1'b0; end_op = 1'b0; m_ready = 1'b0;
      tick; tick;
      @(negedge clk);
      n_checks++;
      if ({stall, m_valid, m_last, frame_done, ovf_err} !== 5'b0)
         $display("[TB] FAIL reset_flags got %b exp 00000", {stall, m_valid, m_last, frame_done, ovf_err});
      else n_pass++;
      n_checks++;
      if (m_data !== '0) $display("[TB] FAIL reset_data got %h exp 0", m_data);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_quant_corners;
      logic [31:0]       lanes [8];
      logic [IN_W*S-1:0] row;
      logic [8*S-1:0]    exp_row;
      logic [OUT_W-1:0]  b0;
      logic [63:0]       k;
      int                got;
      m_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         rand_row(row);
         if (c < 2) begin
            cfg_shift = 5'd4; cfg_relu = (c == 1);
            lanes[0] = 32'h00000008; lanes[1] = 32'h00000007;
            lanes[2] = 32'hFFFFFFF8; lanes[3] = 32'hFFFFFFF7;
            lanes[4] = 32'h00001000; lanes[5] = 32'hFFFFF000;
            lanes[6] = 32'h7FFFFFFF; lanes[7] = 32'h80000000;
            for (int i = 0; i < 8; i++) row[32*i +: 32] = lanes[i];
            k = (c == 0) ? 64'h807F807F_FF000001 : 64'h007F007F_00000001;
         end else begin
            cfg_shift = 5'd0; cfg_relu = 1'b0;
            row[31:0] = 32'd5; row[63:32] = 32'hFFFFFFFB; row[95:64] = 32'd200;
            k = 64'h00000000_007FFB05;
         end
         exp_row = row_model(row, int'(cfg_shift), cfg_relu);
         ofm_port = row; ofm_port_v = 1'b1;
         tick;
         ofm_port_v = 1'b0;
         got = 0; b0 = '0;
         for (int n = 0; n < 20 && got < 4; n++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
               n_checks++;
               if (m_data !== exp_row[got*OUT_W +: OUT_W])
                  $display("[TB] FAIL corner_beat%0d got %h exp %h", got, m_data, exp_row[got*OUT_W +: OUT_W]);
               else n_pass++;
               if (got == 0) b0 = m_data;
               got++;
            end
            @(posedge clk); #1;
         end
         n_checks++;
         if (got !== 4) $display("[TB] FAIL corner_beats_seen got %0d exp 4", got);
         else n_pass++;
         n_checks++;
         if (c < 2 && b0[63:0] !== k) $display("[TB] FAIL corner_bytes%0d got %h exp %h", c, b0[63:0], k);
         else if (c == 2 && b0[23:0] !== k[23:0]) $display("[TB] FAIL shift0_bytes got %h exp %h", b0[23:0], k[23:0]);
         else n_pass++;
      end
   endtask

   task automatic test_latency;
      logic [IN_W*S-1:0] row;
      logic [8*S-1:0]    exp_row;
      bit                ev;
      m_ready = 1'b1;
      cfg_shift = 5'($urandom_range(1, 12)); cfg_relu = 1'($urandom_range(0, 1));
      rand_row(row);
      exp_row = row_model(row, int'(cfg_shift), cfg_relu);
      ofm_port = row; ofm_port_v = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         ev = (k >= 2 && k <= 5);
         n_checks++;
         if (m_valid !== ev) $display("[TB] FAIL lat_valid_c%0d got %b exp %b", k, m_valid, ev);
         else n_pass++;
         n_checks++;
         if (m_last !== (k == 5)) $display("[TB] FAIL lat_last_c%0d got %b exp %b", k, m_last, (k == 5));
         else n_pass++;
         if (ev) begin
            n_checks++;
            if (m_data !== exp_row[(k-2)*OUT_W +: OUT_W])
               $display("[TB] FAIL lat_data_c%0d got %h exp %h", k, m_data, exp_row[(k-2)*OUT_W +: OUT_W]);
            else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 0) ofm_port_v = 1'b0;
      end
   endtask

   task automatic test_backpressure;
      logic [IN_W*S-1:0] row;
      logic [8*S-1:0]    head;
      logic [OUT_W-1:0]  hold;
      int                cum [16];
      int                sent, bidx, vk;
      bit                have, es;
      m_ready = 1'b0; sent = 0; have = 1'b0; hold = '0;
      cfg_shift = 5'($urandom_range(0, 8)); cfg_relu = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) begin
         if (!stall && sent < 10) begin
            rand_row(row); ofm_port = row; ofm_port_v = 1'b1;
            exp_q.push_back(row_model(row, int'(cfg_shift), cfg_relu));
            sent++; vk = 1;
         end else begin
            ofm_port_v = 1'b0; vk = 0;
         end
         cum[k] = ((k > 0) ? cum[k-1] : 0) + vk;
         @(negedge clk);
         es = (k >= 2) && (cum[(k >= 2) ? k-2 : 0] >= 5);
         n_checks++;
         if (stall !== es) $display("[TB] FAIL bp_stall_c%0d got %b exp %b", k, stall, es);
         else n_pass++;
         if (m_valid) begin
            if (!have) begin
               hold = m_data; have = 1'b1;
            end else begin
               n_checks++;
               if (m_data !== hold) $display("[TB] FAIL bp_hold_c%0d got %h exp %h", k, m_data, hold);
               else n_pass++;
            end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (sent !== 6) $display("[TB] FAIL bp_rows_admitted got %0d exp 6", sent);
      else n_pass++;
      m_ready = 1'b1; bidx = 0;
      for (int k = 0; k < 200 && (sent < 10 || exp_q.size() > 0); k++) begin
         if (!stall && sent < 10) begin
            rand_row(row); ofm_port = row; ofm_port_v = 1'b1;
            exp_q.push_back(row_model(row, int'(cfg_shift), cfg_relu));
            sent++;
         end else begin
            ofm_port_v = 1'b0;
         end
         @(negedge clk);
         if (m_valid && m_ready && exp_q.size() > 0) begin
            head = exp_q[0];
            n_checks++;
            if (m_data !== head[bidx*OUT_W +: OUT_W] || m_last !== (bidx == 3))
               $display("[TB] FAIL bp_beat got %h/%b exp %h/%b", m_data, m_last, head[bidx*OUT_W +: OUT_W], (bidx == 3));
            else n_pass++;
            if (bidx == 3) begin
               void'(exp_q.pop_front()); bidx = 0;
            end else bidx++;
         end
         @(posedge clk); #1;
      end
      ofm_port_v = 1'b0;
      n_checks++;
      if (exp_q.size() != 0 || sent != 10 || ovf_err !== 1'b0)
         $display("[TB] FAIL bp_drain got left=%0d sent=%0d ovf=%b exp 0/10/0", exp_q.size(), sent, ovf_err);
      else n_pass++;
   endtask

   task automatic test_overflow;
      logic [IN_W*S-1:0] row;
      logic [8*S-1:0]    head;
      int                rows_out, bidx;
      m_ready = 1'b0;
      cfg_shift = 5'($urandom_range(0, 10)); cfg_relu = 1'($urandom_range(0, 1));
      for (int k = 0; k < 9; k++) begin
         rand_row(row); ofm_port = row; ofm_port_v = 1'b1;
         if (k < 8) exp_q.push_back(row_model(row, int'(cfg_shift), cfg_relu));
         tick;
      end
      ofm_port_v = 1'b0;
      tick; tick; tick;
      @(negedge clk);
      n_checks++;
      if (ovf_err !== 1'b1) $display("[TB] FAIL ovf_set got %b exp 1", ovf_err);
      else n_pass++;
      @(posedge clk); #1;
      m_ready = 1'b1; rows_out = 0; bidx = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (m_valid && m_ready) begin
            if (exp_q.size() > 0) begin
               head = exp_q[0];
               n_checks++;
               if (m_data !== head[bidx*OUT_W +: OUT_W])
                  $display("[TB] FAIL ovf_beat got %h exp %h", m_data, head[bidx*OUT_W +: OUT_W]);
               else n_pass++;
            end
            if (bidx == 3) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               rows_out++; bidx = 0;
            end else bidx++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (rows_out !== 8) $display("[TB] FAIL ovf_rows_out got %0d exp 8", rows_out);
      else n_pass++;
      n_checks++;
      if (ovf_err !== 1'b1) $display("[TB] FAIL ovf_sticky got %b exp 1", ovf_err);
      else n_pass++;
      rst = 1'b1; tick; rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ovf_err !== 1'b0) $display("[TB] FAIL ovf_clear got %b exp 0", ovf_err);
      else n_pass++;
      @(posedge clk); #1;
      exp_q.delete();
   endtask

   task automatic test_frame;
      logic [IN_W*S-1:0] row;
      logic [8*S-1:0]    head;
      int                last_hs, fd_n, fd_k, bidx;
      m_ready = 1'b1; last_hs = -100; fd_n = 0; fd_k = -1; bidx = 0;
      cfg_shift = 5'($urandom_range(0, 10)); cfg_relu = 1'($urandom_range(0, 1));
      for (int k = 0; k < 40; k++) begin
         if (k < 3) begin
            rand_row(row); ofm_port = row; ofm_port_v = 1'b1;
            exp_q.push_back(row_model(row, int'(cfg_shift), cfg_relu));
         end else ofm_port_v = 1'b0;
         end_op = (k == 3);
         @(negedge clk);
         if (m_valid && m_ready && exp_q.size() > 0) begin
            head = exp_q[0];
            n_checks++;
            if (m_data !== head[bidx*OUT_W +: OUT_W])
               $display("[TB] FAIL frame_beat got %h exp %h", m_data, head[bidx*OUT_W +: OUT_W]);
            else n_pass++;
            if (bidx == 3) begin
               void'(exp_q.pop_front()); bidx = 0; last_hs = k;
            end else bidx++;
         end
         if (frame_done) begin
            fd_n++; fd_k = k;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (fd_n !== 1 || fd_k !== last_hs + 1)
         $display("[TB] FAIL frame_done_drain got n=%0d at %0d exp n=1 at %0d", fd_n, fd_k, last_hs + 1);
      else n_pass++;
      fd_n = 0; fd_k = -1;
      for (int k = 0; k < 8; k++) begin
         end_op = (k == 2 || k == 3);
         @(negedge clk);
         if (frame_done) begin
            fd_n++; fd_k = k;
         end
         @(posedge clk); #1;
      end
      end_op = 1'b0;
      n_checks++;
      if (fd_n !== 1 || fd_k !== 3)
         $display("[TB] FAIL frame_done_idle got n=%0d at %0d exp n=1 at 3", fd_n, fd_k);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic [IN_W*S-1:0] row;
      int                vcount;
      m_ready = 1'b1;
      rand_row(row); ofm_port = row; ofm_port_v = 1'b1; tick;
      rand_row(row); ofm_port = row; tick;
      ofm_port_v = 1'b0; tick;
      rst = 1'b1; rand_row(row); ofm_port = row; ofm_port_v = 1'b1;
      tick;
      rst = 1'b0; ofm_port_v = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({stall, m_valid, m_last, frame_done, ovf_err} !== 5'b0)
         $display("[TB] FAIL rstmid_flags got %b exp 00000", {stall, m_valid, m_last, frame_done, ovf_err});
      else n_pass++;
      n_checks++;
      if (m_data !== '0) $display("[TB] FAIL rstmid_data got %h exp 0", m_data);
      else n_pass++;
      vcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (m_valid) vcount++;
      end
      n_checks++;
      if (vcount !== 0) $display("[TB] FAIL rstmid_stale got %0d exp 0", vcount);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      logic [IN_W*S-1:0] row;
      logic [8*S-1:0]    head;
      logic [OUT_W-1:0]  prev_data;
      bit                prev_wait;
      int                sent, bidx;
      for (int run = 0; run < 3; run++) begin
         cfg_shift = 5'($urandom_range(0, 20)); cfg_relu = 1'($urandom_range(0, 1));
         sent = 0; bidx = 0; prev_wait = 1'b0; prev_data = '0;
         for (int k = 0; k < 2000 && (sent < 40 || exp_q.size() > 0); k++) begin
            m_ready = ($urandom_range(0, 99) < 60);
            if (!stall && sent < 40 && $urandom_range(0, 1) == 1) begin
               rand_row(row); ofm_port = row; ofm_port_v = 1'b1;
               exp_q.push_back(row_model(row, int'(cfg_shift), cfg_relu));
               sent++;
            end else ofm_port_v = 1'b0;
            @(negedge clk);
            if (prev_wait) begin
               n_checks++;
               if (m_valid !== 1'b1 || m_data !== prev_data)
                  $display("[TB] FAIL rand_hold got %b/%h exp 1/%h", m_valid, m_data, prev_data);
               else n_pass++;
            end
            if (m_valid && m_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  $display("[TB] FAIL rand_extra_beat got %h exp none", m_data);
               end else begin
                  head = exp_q[0];
                  if (m_data !== head[bidx*OUT_W +: OUT_W] || m_last !== (bidx == 3))
                     $display("[TB] FAIL rand_beat got %h/%b exp %h/%b", m_data, m_last, head[bidx*OUT_W +: OUT_W], (bidx == 3));
                  else n_pass++;
                  if (bidx == 3) begin
                     void'(exp_q.pop_front()); bidx = 0;
                  end else bidx++;
               end
            end
            prev_wait = m_valid && !m_ready;
            prev_data = m_data;
            @(posedge clk); #1;
         end
         ofm_port_v = 1'b0;
         n_checks++;
         if (exp_q.size() != 0 || sent != 40)
            $display("[TB] FAIL rand_drain_run%0d got left=%0d sent=%0d exp 0/40", run, exp_q.size(), sent);
         else n_pass++;
      end
      n_checks++;
      if (ovf_err !== 1'b0) $display("[TB] FAIL rand_ovf got %b exp 0", ovf_err);
      else n_pass++;
   endtask

   initial begin
      test_reset;
      test_quant_corners;
      test_latency;
      test_backpressure;
      test_overflow;
      test_frame;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
